pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central pipeline controller for the SIMD AES pipelined core. It sequences the IF/ID, ID/EX and EX/MEM stage registers: it stalls for multi-cycle vector (AES round) operations and load-use hazards, flushes on taken branches, and selects EX operand forwarding. It sits beside the datapath and drives the enable, flush and bubble controls of the stage registers and the PC.

## Interface
- VLAT, 4: EX occupancy in cycles of a vector op; legal range 1..64; 1 = no vector stall
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- ID_rs1, ID_rs2  in  5  source registers of the instruction in ID
- ID_UsesRs1, ID_UsesRs2  in  1  ID instruction actually reads rs1/rs2
- EX_rs1, EX_rs2  in  5  source registers of the instruction in EX
- EX_rd  in  5  destination of the EX instruction
- EX_RegWrite  in  1  EX instruction writes the scalar register file
- EX_MemToReg  in  2  2'b01 = load
- EX_VStart  in  1  EX holds a multi-cycle vector op
- EX_BranchTaken  in  1  EX resolved a taken branch/jump
- MEM_rd, WB_rd  in  5  destinations in MEM and WB
- MEM_RegWrite, WB_RegWrite  in  1  write enables in MEM and WB
- PC_En  out  1  PC update enable
- IFID_En, IDEX_En  out  1  stage register enables
- IFID_Flush, IDEX_Flush  out  1  load a NOP into the register at the next edge
- EXMEM_Bubble  out  1  EX/MEM captures zeroed RegWrite/MemWrite/VRegWrite
- ForwardA, ForwardB  out  2  EX operand select: 00 = register file, 10 = MEM, 01 = WB
- VBusy  out  1  vector sequencer active (state VWAIT)
- StallCnt  out  16  count of cycles with PC_En=0, saturating

## Operation
- State machine: RUN and VWAIT. Down-counter cnt is 6 bits wide.
- All outputs except StallCnt are combinational from state, cnt and the inputs.
- Idle values, which are also the reset values: PC_En=IFID_En=IDEX_En=1; flushes=0; EXMEM_Bubble=0; VBusy=0; Forward=00. StallCnt resets to 0.
- Priority in RUN: branch > vector > load-use.
- Branch (RUN, EX_BranchTaken=1):
  - IFID_Flush=1, IDEX_Flush=1, PC_En=1.
  - No stall in this cycle.
- Vector start (RUN, EX_VStart=1, VLAT>=2):
  - PC_En=IFID_En=IDEX_En=0, EXMEM_Bubble=1.
  - Next state is VWAIT with cnt<=VLAT-2.
  - If VLAT=1, EX_VStart is ignored.
- VWAIT, cnt!=0: same stall outputs as vector start; cnt decrements.
- VWAIT, cnt==0:
  - Release cycle: idle outputs, EX/MEM captures the vector result, next state RUN.
  - EX_VStart is ignored in this cycle because the same instruction is still in EX.
- Load-use (RUN, no branch or vector condition):
  - Condition: EX_MemToReg==2'b01, EX_RegWrite=1, EX_rd!=0, and (ID_UsesRs1 and ID_rs1==EX_rd) or (ID_UsesRs2 and ID_rs2==EX_rd).
  - Outputs: PC_En=0, IFID_En=0, IDEX_Flush=1.
  - Lasts exactly one cycle; no state change.
- Forwarding (any state), shown for ForwardA; ForwardB uses EX_rs2:
  - 10 if MEM_RegWrite, MEM_rd!=0 and MEM_rd==EX_rs1.
  - Otherwise 01 if WB_RegWrite, WB_rd!=0 and WB_rd==EX_rs1.
  - Otherwise 00. MEM has priority over WB.
- EX_BranchTaken in VWAIT: ignored; a vector op never branches.
- StallCnt increments on each cycle with PC_En=0 and holds at 16'hFFFF.

## Timing
- Vector op entering EX at cycle T:
  - Stalled cycles are T..T+VLAT-2, i.e. VLAT-1 stall cycles.
  - Release is at T+VLAT-1; the next instruction is in EX at T+VLAT.
- Load-use adds exactly 1 bubble; the dependent instruction enters EX one cycle late.
- Branch costs exactly 2 flushed slots, with no stall cycle.
- rst sampled at an edge:
  - Next cycle: RUN, cnt=0, StallCnt=0, idle outputs.
  - This holds mid-VWAIT; the in-flight vector op is abandoned.
- StallCnt updates at the edge that closes the stalled cycle, so it is visible one cycle later.

## Test plan
- Reset, then no hazards for 10 cycles:
  - All enables stay 1, flushes stay 0.
  - StallCnt=0, ForwardA=ForwardB=00.
- EX_VStart held with VLAT=4:
  - PC_En=0 and EXMEM_Bubble=1 for 3 cycles, with VBusy=1 on the last 2 of them.
  - 4th cycle is idle.
  - StallCnt=3.
- Load to x5 in EX, ID reads x5 with ID_UsesRs1=1:
  - One cycle with PC_En=0, IFID_En=0, IDEX_Flush=1.
  - Repeat with EX_rd=0: no stall.
- EX_BranchTaken=1 together with a load-use match:
  - IFID_Flush=IDEX_Flush=1, PC_En=1.
  - No stall.
- MEM_rd=WB_rd=EX_rs1=7, both write enables set:
  - ForwardA=10.
  - Clear MEM_RegWrite: ForwardA=01. Set EX_rs1=0: ForwardA=00.
- rst asserted during the 2nd VWAIT cycle (VLAT=8):
  - Next cycle all outputs idle, VBusy=0, StallCnt=0.
  - Then 20000 back-to-back vector ops: StallCnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: vector-op stall sequencer, load-use
// interlock, branch flush and EX operand forwarding select.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   ID_*, EX_*         source/dest info of the ID and EX instructions
//   MEM_*, WB_*        destination info of MEM and WB (forwarding)
//   PC_En, *_En        PC and stage-register enables
//   *_Flush            load a NOP into the stage register next edge
//   EXMEM_Bubble       zero EX/MEM write enables
//   ForwardA/B         00 regfile, 10 MEM, 01 WB
//   VBusy              vector sequencer is counting down
//   StallCnt           saturating count of PC_En=0 cycles
module pipeline_hazard_ctrl #(
  parameter int VLAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ID_rs1,
  input  logic [4:0]  ID_rs2,
  input  logic        ID_UsesRs1,
  input  logic        ID_UsesRs2,
  input  logic [4:0]  EX_rs1,
  input  logic [4:0]  EX_rs2,
  input  logic [4:0]  EX_rd,
  input  logic        EX_RegWrite,
  input  logic [1:0]  EX_MemToReg,
  input  logic        EX_VStart,
  input  logic        EX_BranchTaken,
  input  logic [4:0]  MEM_rd,
  input  logic [4:0]  WB_rd,
  input  logic        MEM_RegWrite,
  input  logic        WB_RegWrite,
  output logic        PC_En,
  output logic        IFID_En,
  output logic        IDEX_En,
  output logic        IFID_Flush,
  output logic        IDEX_Flush,
  output logic        EXMEM_Bubble,
  output logic [1:0]  ForwardA,
  output logic [1:0]  ForwardB,
  output logic        VBusy,
  output logic [15:0] StallCnt
);

  typedef enum logic {
    RUN,
    VWAIT
  } state_t;

  // The start cycle is itself a stall, so VWAIT counts VLAT-2 more.
  localparam logic [5:0] CNT_INIT = 6'(VLAT - 2);
  localparam bit         VEC_EN   = (VLAT >= 2);

  state_t     state, state_n;
  logic [5:0] cnt, cnt_n;
  logic       load_use;
  logic       hit1, hit2;

  assign hit1 = ID_UsesRs1 && (ID_rs1 == EX_rd);
  assign hit2 = ID_UsesRs2 && (ID_rs2 == EX_rd);

  assign load_use = (EX_MemToReg == 2'b01)
                 && EX_RegWrite
                 && (EX_rd != 5'd0)
                 && (hit1 || hit2);

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    PC_En        = 1'b1;
    IFID_En      = 1'b1;
    IDEX_En      = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Flush   = 1'b0;
    EXMEM_Bubble = 1'b0;
    VBusy        = 1'b0;
    unique case (state)
      RUN: begin
        if (EX_BranchTaken) begin
          IFID_Flush = 1'b1;
          IDEX_Flush = 1'b1;
        end else if (EX_VStart && VEC_EN) begin
          PC_En        = 1'b0;
          IFID_En      = 1'b0;
          IDEX_En      = 1'b0;
          EXMEM_Bubble = 1'b1;
          state_n      = VWAIT;
          cnt_n        = CNT_INIT;
        end else if (load_use) begin
          PC_En      = 1'b0;
          IFID_En    = 1'b0;
          IDEX_Flush = 1'b1;
        end
      end
      VWAIT: begin
        if (cnt != 6'd0) begin
          PC_En        = 1'b0;
          IFID_En      = 1'b0;
          IDEX_En      = 1'b0;
          EXMEM_Bubble = 1'b1;
          VBusy        = 1'b1;
          cnt_n        = cnt - 6'd1;
        end else begin
          // Release: EX/MEM captures the vector result this edge.
          state_n = RUN;
        end
      end
      default: state_n = RUN;
    endcase
  end

  // MEM is younger than WB, so its value wins.
  always_comb begin
    ForwardA = 2'b00;
    ForwardB = 2'b00;
    if (MEM_RegWrite && MEM_rd != 5'd0 && MEM_rd == EX_rs1)
      ForwardA = 2'b10;
    else if (WB_RegWrite && WB_rd != 5'd0 && WB_rd == EX_rs1)
      ForwardA = 2'b01;
    if (MEM_RegWrite && MEM_rd != 5'd0 && MEM_rd == EX_rs2)
      ForwardB = 2'b10;
    else if (WB_RegWrite && WB_rd != 5'd0 && WB_rd == EX_rs2)
      ForwardB = 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      cnt      <= 6'd0;
      StallCnt <= 16'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (!PC_En && StallCnt != 16'hFFFF)
        StallCnt <= StallCnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl, two instances
// (VLAT=4 and VLAT=8) sharing one stimulus set.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] ID_rs1, ID_rs2, EX_rs1, EX_rs2, EX_rd;
  logic [4:0] MEM_rd, WB_rd;
  logic       ID_UsesRs1, ID_UsesRs2, EX_RegWrite;
  logic       EX_VStart, EX_BranchTaken;
  logic       MEM_RegWrite, WB_RegWrite;
  logic [1:0] EX_MemToReg;

  logic        pc4, ifen4, iden4, iff4, idf4, bub4, vb4;
  logic [1:0]  fa4, fb4;
  logic [15:0] sc4;
  logic        pc8, ifen8, iden8, iff8, idf8, bub8, vb8;
  logic [1:0]  fa8, fb8;
  logic [15:0] sc8;

  logic [6:0] ctl4, ctl8;
  assign ctl4 = {pc4, ifen4, iden4, iff4, idf4, bub4, vb4};
  assign ctl8 = {pc8, ifen8, iden8, iff8, idf8, bub8, vb8};

  localparam logic [6:0] IDLE   = 7'b1110000;
  localparam logic [6:0] VSTART = 7'b0000010;
  localparam logic [6:0] VWAITS = 7'b0000011;
  localparam logic [6:0] LDUSE  = 7'b0010100;
  localparam logic [6:0] BRANCH = 7'b1111100;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.VLAT(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_UsesRs1(ID_UsesRs1), .ID_UsesRs2(ID_UsesRs2),
    .EX_rs1(EX_rs1), .EX_rs2(EX_rs2), .EX_rd(EX_rd),
    .EX_RegWrite(EX_RegWrite), .EX_MemToReg(EX_MemToReg),
    .EX_VStart(EX_VStart), .EX_BranchTaken(EX_BranchTaken),
    .MEM_rd(MEM_rd), .WB_rd(WB_rd),
    .MEM_RegWrite(MEM_RegWrite), .WB_RegWrite(WB_RegWrite),
    .PC_En(pc4), .IFID_En(ifen4), .IDEX_En(iden4),
    .IFID_Flush(iff4), .IDEX_Flush(idf4),
    .EXMEM_Bubble(bub4),
    .ForwardA(fa4), .ForwardB(fb4),
    .VBusy(vb4), .StallCnt(sc4)
  );

  pipeline_hazard_ctrl #(.VLAT(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_UsesRs1(ID_UsesRs1), .ID_UsesRs2(ID_UsesRs2),
    .EX_rs1(EX_rs1), .EX_rs2(EX_rs2), .EX_rd(EX_rd),
    .EX_RegWrite(EX_RegWrite), .EX_MemToReg(EX_MemToReg),
    .EX_VStart(EX_VStart), .EX_BranchTaken(EX_BranchTaken),
    .MEM_rd(MEM_rd), .WB_rd(WB_rd),
    .MEM_RegWrite(MEM_RegWrite), .WB_RegWrite(WB_RegWrite),
    .PC_En(pc8), .IFID_En(ifen8), .IDEX_En(iden8),
    .IFID_Flush(iff8), .IDEX_Flush(idf8),
    .EXMEM_Bubble(bub8),
    .ForwardA(fa8), .ForwardB(fb8),
    .VBusy(vb8), .StallCnt(sc8)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are driven 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    ID_rs1 = 0; ID_rs2 = 0; ID_UsesRs1 = 0; ID_UsesRs2 = 0;
    EX_rs1 = 0; EX_rs2 = 0; EX_rd = 0;
    EX_RegWrite = 0; EX_MemToReg = 2'b00;
    EX_VStart = 0; EX_BranchTaken = 0;
    MEM_rd = 0; WB_rd = 0;
    MEM_RegWrite = 0; WB_RegWrite = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    clear();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Idle after reset
    @(negedge clk);
    chk("rst_ctl", ctl4, IDLE);
    chk("rst_sc", sc4, 0);
    chk("rst_fwd", {fa4, fb4}, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      step();
      @(negedge clk);
      chk("idle_ctl", ctl4, IDLE);
    end
    chk("idle_sc", sc4, 0);
    chk("idle_fwd", {fa4, fb4}, 4'b0000);

    // Vector op, VLAT=4, VStart held through release
    step();
    EX_VStart = 1;
    @(negedge clk); chk("v4_t0", ctl4, VSTART);
    step(); @(negedge clk); chk("v4_t1", ctl4, VWAITS);
    step(); @(negedge clk); chk("v4_t2", ctl4, VWAITS);
    step(); @(negedge clk); chk("v4_rel", ctl4, IDLE);
    chk("v4_sc_rel", sc4, 3);
    step();
    EX_VStart = 0;
    @(negedge clk);
    chk("v4_after", ctl4, IDLE);
    chk("v4_sc", sc4, 3);

    // Load-use on rs1
    step();
    EX_MemToReg = 2'b01; EX_RegWrite = 1; EX_rd = 5;
    ID_rs1 = 5; ID_UsesRs1 = 1;
    @(negedge clk); chk("lu_rs1", ctl4, LDUSE);
    step();
    EX_MemToReg = 2'b00; EX_RegWrite = 0; EX_rd = 0;
    @(negedge clk);
    chk("lu_one", ctl4, IDLE);
    chk("lu_sc", sc4, 4);

    // Load-use on rs2, and the non-hazard variants
    EX_MemToReg = 2'b01; EX_RegWrite = 1; EX_rd = 5;
    ID_UsesRs1 = 0; ID_rs2 = 5; ID_UsesRs2 = 1;
    #1 chk("lu_rs2", ctl4, LDUSE);
    ID_UsesRs2 = 0;
    #1 chk("lu_unused", ctl4, IDLE);
    ID_UsesRs1 = 1; EX_rd = 0; ID_rs1 = 0;
    #1 chk("lu_x0", ctl4, IDLE);
    EX_rd = 5; ID_rs1 = 5; EX_MemToReg = 2'b10;
    #1 chk("lu_notload", ctl4, IDLE);
    EX_MemToReg = 2'b01; EX_RegWrite = 0;
    #1 chk("lu_nowr", ctl4, IDLE);
    EX_RegWrite = 1;

    // Branch beats load-use, then vector
    EX_BranchTaken = 1;
    #1 chk("br_lu", ctl4, BRANCH);
    EX_VStart = 1;
    #1 chk("br_vec", ctl4, BRANCH);
    step();
    clear();
    @(negedge clk);
    chk("br_nostate", ctl4, IDLE);

    // Forwarding
    MEM_rd = 7; WB_rd = 7; EX_rs1 = 7; EX_rs2 = 7;
    MEM_RegWrite = 1; WB_RegWrite = 1;
    #1 chk("fwd_mem", {fa4, fb4}, 4'b1010);
    MEM_RegWrite = 0;
    #1 chk("fwd_wb", {fa4, fb4}, 4'b0101);
    EX_rs1 = 0;
    #1 chk("fwd_rs1_0", {fa4, fb4}, 4'b0001);
    MEM_rd = 0; WB_rd = 0; MEM_RegWrite = 1; EX_rs2 = 0;
    #1 chk("fwd_x0", {fa4, fb4}, 4'b0000);
    EX_rs2 = 3; WB_rd = 3;
    #1 chk("fwd_b_wb", {fa4, fb4}, 4'b0001);
    clear();

    // Reset mid-VWAIT, VLAT=8
    do_reset();
    EX_VStart = 1;
    @(negedge clk); chk("v8_t0", ctl8, VSTART);
    step(); @(negedge clk); chk("v8_w1", ctl8, VWAITS);
    MEM_rd = 9; EX_rs1 = 9; MEM_RegWrite = 1;
    #1 chk("v8_fwd", fa8, 2'b10);
    step();
    EX_VStart = 0; MEM_RegWrite = 0;
    @(negedge clk); chk("v8_w2", ctl8, VWAITS);
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    chk("v8_rst_ctl", ctl8, IDLE);
    chk("v8_rst_sc", sc8, 0);
    step(); @(negedge clk);
    chk("v8_rst_hold", ctl8, IDLE);

    // Back-to-back vector ops: 7 stalls per 8 cycles
    clear();
    EX_VStart = 1;
    repeat (800) step();
    @(negedge clk);
    chk("sat_mid_sc", sc8, 700);
    chk("sat_mid_ctl", ctl8, VSTART);
    repeat (8 * 9300) step();
    @(negedge clk);
    chk("sat_sc", sc8, 16'hFFFF);
    repeat (16) step();
    @(negedge clk);
    chk("sat_hold", sc8, 16'hFFFF);
    EX_VStart = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
